// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of N_PORTS FIFO heads into one registered valid/ready output stage.
// A grant lasts until its FIFO empties or BURST words have been popped, then one IDLE cycle re-arbitrates.
module fifo_rr_scheduler #(
  parameter int N_PORTS = 4,
  parameter int BITS    = 8,
  parameter int BURST   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         pndng_i,
  input  logic [N_PORTS*BITS-1:0]    dout_i,
  output logic [N_PORTS-1:0]         pop_o,
  output logic [BITS-1:0]            out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic                       busy
);
  localparam int GW = $clog2(N_PORTS);
  localparam int CW = $clog2(BURST+1);
  localparam logic [CW-1:0] BURST_C  = CW'(BURST);
  localparam logic [CW-1:0] BURST_M1 = CW'(BURST-1);
  localparam logic [GW-1:0] LAST_RST = GW'(N_PORTS-1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                        state;
  logic [CW-1:0]                 burst_cnt;
  logic [GW-1:0]                 last_grant;
  logic [N_PORTS-1:0][BITS-1:0]  heads;
  logic                          slot_free, pend_g, pop_g, burst_end, exit_xfer, found;
  logic [GW-1:0]                 next_grant, cand;
  logic [BITS-1:0]               head_g;

  assign heads     = dout_i;
  assign head_g    = heads[grant_id];
  assign pend_g    = pndng_i[grant_id];
  assign slot_free = !out_valid | out_ready;
  assign pop_g     = (state == XFER) & pend_g & (burst_cnt < BURST_C) & slot_free;
  // The last allowed pop ends the grant on the same edge it happens.
  assign burst_end = (burst_cnt == BURST_C) | (pop_g & (burst_cnt == BURST_M1));
  assign exit_xfer = slot_free & (!pend_g | burst_end);
  assign busy      = (state == XFER);

  for (genvar k = 0; k < N_PORTS; k++) begin : g_pop
    assign pop_o[k] = pop_g & (grant_id == GW'(k));
  end

  // First pending port after last_grant, wrapping; last_grant itself is tried last.
  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    cand       = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      cand = GW'((int'(last_grant) + i) % N_PORTS);
      if (!found && pndng_i[cand]) begin
        found      = 1'b1;
        next_grant = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      grant_id   <= '0;
      burst_cnt  <= '0;
      last_grant <= LAST_RST;
    end else begin
      case (state)
        IDLE: begin
          if (out_ready) out_valid <= 1'b0;
          if (found) begin
            grant_id  <= next_grant;
            burst_cnt <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (pop_g) begin
            out_data  <= head_g;
            out_valid <= 1'b1;
            burst_cnt <= burst_cnt + 1'b1;
          end else if (slot_free) begin
            out_valid <= 1'b0;
          end
          if (exit_xfer) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: queue-backed FIFOs, a cycle model built from the scheduling rules,
// a table of arbitration vectors, directed corner sequences and a randomized soak.
module tb_fifo_rr_scheduler;
  localparam int N = 4, BITS = 8, BURST = 4;

  logic            clk = 1'b0, rst = 1'b0;
  logic [N-1:0]    pndng_i = '0;
  logic [N*BITS-1:0] dout_i = '0;
  logic [N-1:0]    pop_o;
  logic [BITS-1:0] out_data;
  logic            out_valid, busy;
  logic            out_ready = 1'b1;
  logic [1:0]      grant_id;

  int n_cmp = 0, n_err = 0;
  logic [7:0] q [N][$];
  logic [7:0] got[$], exp_q[$];

  // reference model state
  bit         m_xfer, m_ov;
  int         m_g, m_cnt, m_last;
  logic [7:0] m_od;

  typedef struct { logic [N-1:0] pend; int exp_g; } vec_t;
  vec_t tbl[6];

  fifo_rr_scheduler #(.N_PORTS(N), .BITS(BITS), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .pndng_i(pndng_i), .dout_i(dout_i), .pop_o(pop_o),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(nm, 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      pndng_i[k] = (q[k].size() > 0);
      dout_i[k*BITS +: BITS] = (q[k].size() > 0) ? q[k][0] : 8'h00;
    end
  endtask

  task automatic load(input int k, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) q[k].push_back(8'(base + i));
  endtask

  task automatic model_reset();
    m_xfer = 0; m_ov = 0; m_g = 0; m_cnt = 0; m_last = N-1; m_od = '0;
  endtask

  function automatic bit work_left();
    bit any = m_xfer || m_ov;
    for (int k = 0; k < N; k++) if (q[k].size() > 0) any = 1;
    return any;
  endfunction

  // One clock: compare DUT to model at negedge, advance model, pop FIFOs after the edge.
  task automatic cycle();
    logic [N-1:0] exp_pop;
    bit sf, pop;
    int popk;
    @(negedge clk);
    sf   = !m_ov || out_ready;
    pop  = m_xfer && q[m_g].size() > 0 && m_cnt < BURST && sf;
    popk = m_g;
    exp_pop = '0;
    if (pop) exp_pop[m_g] = 1'b1;
    chk("pop_o", 32'(pop_o), 32'(exp_pop));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) chk("out_data", 32'(out_data), 32'(m_od));
    chk("grant_id", 32'(grant_id), 32'(m_g));
    chk("busy", 32'(busy), 32'(m_xfer));
    if (out_valid && out_ready) got.push_back(out_data);
    if (!m_xfer) begin
      if (m_ov && out_ready) m_ov = 0;
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_last + i) % N;
        if (q[k].size() > 0) begin
          m_g = k; m_cnt = 0; m_xfer = 1;
          break;
        end
      end
    end else begin
      if (pop) begin
        m_od = q[m_g][0]; m_ov = 1; m_cnt++;
      end else if (sf) begin
        m_ov = 0;
      end
      if (sf && (q[m_g].size() == 0 || m_cnt == BURST)) begin
        m_last = m_g; m_xfer = 0;
      end
    end
    @(posedge clk); #1;
    if (pop) void'(q[popk].pop_front());
    drive();
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    out_ready = 1'b1;
    while (work_left() && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_done", 32'(work_left()), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) q[k].delete();
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int pushed;
    logic [7:0] held;

    tbl[0] = '{4'b1111, 0};
    tbl[1] = '{4'b0100, 2};
    tbl[2] = '{4'b1000, 3};
    tbl[3] = '{4'b1010, 1};
    tbl[4] = '{4'b0110, 1};
    tbl[5] = '{4'b1100, 2};

    // reset with every port pending
    for (int k = 0; k < N; k++) load(k, 8'(16*k + 1), 1);
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pop", 32'(pop_o), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_grant", 32'(grant_id), 32'(0));
    chk("rst_data", 32'(out_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b1;
    cycle();
    chk("rst_first_pop", 32'(pop_o), 32'(4'b0001));
    cycle();
    chk("rst_first_valid", 32'(out_valid), 32'(1));
    drain(100);

    // table: first grant after reset for several pending patterns
    foreach (tbl[t]) begin
      do_reset();
      for (int k = 0; k < N; k++) if (tbl[t].pend[k]) load(k, 8'(16*k), 1);
      drive();
      cycle();
      chk("tbl_grant", 32'(grant_id), 32'(tbl[t].exp_g));
      chk("tbl_pop", 32'(pop_o), 32'(1 << tbl[t].exp_g));
      drain(100);
    end

    // fairness: burst limit alternates ports 0 and 2
    do_reset();
    load(0, 8'h00, 6);
    load(2, 8'h20, 6);
    drive();
    drain(200);
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20, 8'h21, 8'h22, 8'h23, 8'h04, 8'h05, 8'h24, 8'h25};
    chk_seq("fair_order");

    // early end: port 1 empties before its burst limit
    do_reset();
    load(1, 8'hA1, 2);
    load(3, 8'hB1, 3);
    drive();
    drain(200);
    exp_q = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hB3};
    chk_seq("early_order");

    // wrap: last grant 3, ports 0 and 3 pending
    do_reset();
    load(0, 8'h0A, 1);
    load(3, 8'h3A, 1);
    drive();
    drain(100);
    exp_q = '{8'h0A, 8'h3A};
    chk_seq("wrap_order");

    // backpressure: hold out_ready low for 3 cycles with a word pending
    do_reset();
    load(0, 8'h50, 6);
    drive();
    repeat (3) cycle();
    held = out_data;
    chk("bp_valid", 32'(out_valid), 32'(1));
    out_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("bp_hold", 32'(out_data), 32'(held));
      chk("bp_nopop", 32'(pop_o), 32'(0));
    end
    drain(200);
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    chk_seq("bp_order");

    // asynchronous reset during port 2's second pop
    do_reset();
    load(2, 8'h21, 4);
    drive();
    repeat (2) cycle();
    chk("mid_pop", 32'(pop_o), 32'(4'b0100));
    #2 rst = 1'b0;
    #1;
    chk("mid_valid_drop", 32'(out_valid), 32'(0));
    chk("mid_pop_drop", 32'(pop_o), 32'(0));
    chk("mid_busy_drop", 32'(busy), 32'(0));
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    got.delete();
    load(0, 8'h01, 2);
    drive();
    cycle();
    chk("mid_regrant", 32'(grant_id), 32'(0));
    drain(200);
    exp_q = '{8'h01, 8'h02, 8'h22, 8'h23, 8'h24};
    chk_seq("mid_order");

    // randomized soak against the model
    do_reset();
    pushed = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(3, 0) == 0 && q[k].size() < 6) begin
          q[k].push_back(8'($urandom));
          pushed++;
        end
      out_ready = ($urandom_range(3, 0) != 0);
      drive();
      cycle();
    end
    drain(500);
    chk("rand_count", 32'(got.size()), 32'(pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Round-robin scheduler that drains N_PORTS flop-based FIFO queues into one shared output channel with a valid/ready handshake.
- Each cycle it drives at most one pop to the granted FIFO and registers that FIFO's head word into a single output stage.
- A per-grant burst limit bounds how long one queue can hold the channel.
- Sits between the per-requester FIFOs and a single downstream consumer.

Parameters:
- N_PORTS, 4, number of FIFO queues served (2..16).
- BITS, 8, data word width; matches the FIFO word width.
- BURST, 4, maximum words popped per grant before re-arbitration (1..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low (rst=0 resets).
- pndng_i  input  N_PORTS  bit k=1: FIFO k head word is valid on its data output.
- dout_i  input  N_PORTS*BITS  flattened head words; FIFO k occupies bits [k*BITS +: BITS].
- pop_o  output  N_PORTS  one-hot-or-zero pop strobe to the FIFOs; combinational.
- out_data  output  BITS  registered output word.
- out_valid  output  1  out_data holds a word not yet accepted.
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready at a rising edge.
- grant_id  output  $clog2(N_PORTS)  index of the currently granted port; registered.
- busy  output  1  1 while state is XFER.

Behaviour:
- Reset (rst=0, asynchronous) clears all state immediately:
  - state=IDLE, out_valid=0, out_data=0, grant_id=0, burst_cnt=0, last_grant=N_PORTS-1, pop_o=0.
  - Port 0 therefore has first priority after reset.
  - A reset in the middle of a burst discards any registered word; the pop already issued is not undone.
- Slot free: slot_free = !out_valid | out_ready.
- State IDLE:
  - If |pndng_i, select the first k with pndng_i[k]=1, searching last_grant+1, last_grant+2, ... modulo N_PORTS.
  - Register grant_id=k, clear burst_cnt=0, go to XFER.
  - No pop is issued in IDLE.
  - out_valid/out_data keep handshaking in IDLE: a pending word stays until accepted.
- State XFER, with g = grant_id:
  - pop_o[g] = pndng_i[g] & (burst_cnt < BURST) & slot_free. All other pop_o bits are 0.
  - On an edge with pop_o[g]=1: out_data <= dout_i[g], out_valid <= 1, burst_cnt <= burst_cnt+1.
  - On an edge with slot_free & !pop_o[g]: out_valid <= 0.
  - Exit condition: slot_free & (!pndng_i[g] | burst_cnt == BURST), including the case where the final pop happens on this edge (burst_cnt+1 == BURST).
  - On exit: last_grant <= g, go to IDLE.
- Throughput and latency:
  - One word per cycle while out_ready=1.
  - First out_valid rises 2 edges after pndng_i is first seen in IDLE (edge 1: IDLE->XFER; edge 2: pop and capture).
  - Each re-arbitration costs one IDLE cycle with no pop.
- Backpressure:
  - out_ready=0 with out_valid=1 holds out_data and out_valid stable and forces pop_o=0.
  - No word is ever lost or duplicated.
- Boundary rules:
  - A FIFO that empties mid-burst ends the grant early; the next port in rotation is served.
  - A port that becomes pending while another is granted waits its round-robin turn.
  - A port cannot be re-granted while any other port is pending, unless it is the only pending port.
  - burst_cnt width is $clog2(BURST+1); it never exceeds BURST.
  - pndng_i and dout_i are treated as stable within a cycle; no input registering.

Test Plan:
- Reset: hold rst=0 with pndng_i=4'b1111 → pop_o=0, out_valid=0, grant_id=0. Release; first pop_o=4'b0001 exactly 1 cycle after release, out_valid=1 one edge later.
- Fairness: ports 0 and 2 each preloaded with 6 words, BURST=4, out_ready=1 → output order is 4 words from port 0, 4 from port 2, 2 from port 0, 2 from port 2, with exactly one idle cycle at each grant change.
- Early end: port 1 holds 2 words (0xA1, 0xA2), port 3 holds 3 words → out sequence A1, A2, then port 3's words. Grant moves to port 3 after pndng_i[1] falls, with no pop to port 1 while it is empty.
- Backpressure: stream from port 0, drop out_ready for 3 cycles while out_valid=1 → out_data stable, pop_o=0 for those cycles, no duplicated or missing word once out_ready returns.
- Wrap: last_grant=3, pndng_i=4'b1001 → next grant_id=0, then 3 on the following arbitration.
- Reset mid-burst: assert rst=0 asynchronously during port 2's second pop → out_valid drops immediately (not at the next edge). After release, arbitration restarts at port 0.
